mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Pipeline MEM stage. Sits directly downstream of the EX/MEM pipeline register and consumes its outputs: Result, SrcB, funct3, rd, and the control bits.
- Performs RISC-V load/store byte-lane alignment, drives a ready/ack data-memory handshake, and sign/zero-extends load data.
- Stalls upstream while an access is outstanding.
- Registers MEM/WB outputs for the writeback stage.

Parameters:
- DATA_W, 32, datapath width; only 32 is supported.
- ADDR_W, 32, data-memory address width.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset; rst=0 resets.
- ex_valid  in  1  EX/MEM holds a valid instruction.
- mRead  in  1  load.
- mWrite  in  1  store.
- m2Reg  in  1  writeback selects memory data.
- rgWrite  in  1  register write enable.
- funct3  in  3  access size/sign.
- rd  in  5  destination register.
- Result  in  DATA_W  ALU result / effective address.
- SrcB  in  DATA_W  store data.
- stall_o  out  1  hold EX/MEM and all upstream stages.
- dm_req  out  1  memory request.
- dm_we  out  1  1 = write.
- dm_addr  out  ADDR_W  word-aligned address ({Result[ADDR_W-1:2],2'b00}).
- dm_be  out  4  byte enables.
- dm_wdata  out  DATA_W  lane-replicated store data.
- dm_ack  in  1  memory completes the access this cycle; dm_rdata valid.
- dm_rdata  in  DATA_W  read word.
- wb_valid  out  1  MEM/WB entry valid.
- wb_rgWrite  out  1.
- wb_m2Reg  out  1.
- wb_rd  out  5.
- wb_ReadData  out  DATA_W  extended load data.
- wb_Result  out  DATA_W  ALU result passthrough.
- misalign_o  out  1  one-cycle pulse: misaligned or illegal access.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; every output and internal register is 0, including dm_req, stall_o, and all wb_* outputs.
- FSM has two states:
  - IDLE: a "mem op" is ex_valid & (mRead|mWrite). A legal, aligned mem op captures the address, data, funct3, rd and control into internal registers and moves to ACCESS.
  - ACCESS: dm_req=1. dm_we, dm_addr, dm_be and dm_wdata come from the captured registers and stay stable until dm_ack. On dm_ack, return to IDLE and load the MEM/WB outputs.
- stall_o (combinational):
  - 1 when state=IDLE and a legal mem op is present.
  - 1 when state=ACCESS and dm_ack=0.
  - 0 otherwise. In particular, stall_o drops in the ack cycle so upstream advances on the same edge.
- Non-memory instruction (ex_valid, no mRead/mWrite): 1-cycle latency, no stall.
  - wb_valid=1; wb_rgWrite, wb_m2Reg, wb_rd and wb_Result are copied; wb_ReadData=0.
- ex_valid=0 in IDLE: wb_valid=0 and wb_rgWrite=0 next cycle.
- Memory latency: minimum 2 cycles from presentation to wb_valid (dm_ack in the first ACCESS cycle). Each extra cycle of ack delay adds one cycle. wb_valid is a single-cycle pulse per instruction.
- Byte enables by funct3[1:0], with a = address[1:0]:
  - 00 (byte): 4'b0001<<a.
  - 01 (half): 4'b0011<<{a[1],1'b0}.
  - 10 (word): 4'b1111.
- Store data: byte gets {4{SrcB[7:0]}}; half gets {2{SrcB[15:0]}}; word gets SrcB.
- Load extension: select the lane by a. funct3 000 = LB and 001 = LH sign-extend; 100 = LBU and 101 = LHU zero-extend; 010 = LW passes through.
- Misaligned or illegal access, handled in IDLE with no state change, no dm_req and no stall:
  - Misaligned: half with a[0]=1; word with a≠0.
  - Illegal: load funct3 ∈ {011,110,111}; store funct3[2]=1; mRead & mWrite both set.
  - Response next cycle: wb_valid=1, wb_rgWrite=0, misalign_o=1.
- Handshake edge cases:
  - dm_ack while dm_req=0 is ignored.
  - dm_rdata is sampled only in the ack cycle.
- Reset asserted during ACCESS: dm_req and stall_o drop immediately. The captured access is discarded and no wb_valid is produced for it.
- wb_* outputs are registered and hold their values when wb_valid=0, except that wb_rgWrite is cleared.

Decomposition:
- Package mem_pkg holds:
  - funct3 localparams: F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
  - state enum typedef mem_state_t {IDLE, ACCESS}.
  - MEMWB output struct typedef.
- One combinational sub-module, load_store_align, computes be, wdata lane replication, misalign/illegal detection, and load extension. The FSM and registers stay in the top.

Test Plan:
- SB, Result=0x00001003, SrcB=0x000000AB, dm_ack in the first ACCESS cycle -> dm_addr=0x00001000, dm_be=4'b1000, dm_wdata=0xABABABAB, dm_we=1; stall_o high for exactly 1 cycle; wb_valid pulses 1 cycle with wb_rgWrite=0.
- LB at 0x00002002 with dm_rdata=0x12803456 -> wb_ReadData=0xFFFFFF80; the same access as LBU -> 0x00000080; LH at 0x2002 -> 0x00001280.
- LW at 0x00003002 -> no dm_req; misalign_o=1 and wb_valid=1, wb_rgWrite=0 next cycle; stall_o stays 0.
- LW at 0x4000 with dm_ack delayed 3 cycles -> stall_o high for 4 cycles; dm_addr, dm_be and dm_we stable throughout; exactly one wb_valid pulse carrying dm_rdata.
- Back-to-back ALU ops (Result=0xDEADBEEF, rd=7, then 0x1, rd=8) -> wb_Result/wb_rd follow each op one cycle later; stall_o never asserts.
- rst driven low in the second cycle of ACCESS (no ack yet) -> dm_req=0 and stall_o=0 immediately; all wb_* = 0. A stray dm_ack after rst releases produces no wb_valid.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM pipeline stage.
package mem_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic            valid;
        logic            rgWrite;
        logic            m2Reg;
        logic [4:0]      rd;
        logic [XLEN-1:0] ReadData;
        logic [XLEN-1:0] Result;
    } memwb_t;

endpackage

// File: rtl/load_store_align.sv
// Combinational byte-lane logic: store enables/replication, legality check,
// and load lane select with sign/zero extension.
module load_store_align
    import mem_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic            mRead,
    input  logic            mWrite,
    input  logic [XLEN-1:0] sdata,
    input  logic [2:0]      ld_funct3,
    input  logic [1:0]      ld_addr_lo,
    input  logic [XLEN-1:0] rdata,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata,
    output logic            bad,
    output logic [XLEN-1:0] ld_data
);

    logic [XLEN-1:0] shifted;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;

    always_comb begin
        be    = 4'b0000;
        wdata = sdata;
        bad   = 1'b0;
        case (funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{sdata[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << {addr_lo[1], 1'b0};
                wdata = {2{sdata[15:0]}};
                bad   = addr_lo[0];
            end
            2'b10: begin
                be  = 4'b1111;
                bad = (addr_lo != 2'b00);
            end
            default: bad = 1'b1;
        endcase
        // Encodings with no RV32 meaning for the given direction.
        if (mRead && mWrite)
            bad = 1'b1;
        if (mWrite && funct3[2])
            bad = 1'b1;
        if (mRead && (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111))
            bad = 1'b1;
    end

    assign shifted = rdata >> {ld_addr_lo, 3'b000};
    assign ld_byte = shifted[7:0];
    assign ld_half = ld_addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        case (ld_funct3)
            F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            F3_BU:   ld_data = {24'h0, ld_byte};
            F3_HU:   ld_data = {16'h0, ld_half};
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: captures a legal load/store, runs a req/ack memory handshake
// while stalling upstream, and registers the MEM/WB outputs.
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              mRead,
    input  logic              mWrite,
    input  logic              m2Reg,
    input  logic              rgWrite,
    input  logic [2:0]        funct3,
    input  logic [4:0]        rd,
    input  logic [DATA_W-1:0] Result,
    input  logic [DATA_W-1:0] SrcB,
    output logic              stall_o,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [3:0]        dm_be,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic              dm_ack,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic              wb_valid,
    output logic              wb_rgWrite,
    output logic              wb_m2Reg,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_ReadData,
    output logic [DATA_W-1:0] wb_Result,
    output logic              misalign_o
);

    mem_state_t        state;
    memwb_t            wb_q;
    logic              misalign_q;
    logic              cap_we, cap_rgWrite, cap_m2Reg;
    logic [ADDR_W-1:0] cap_addr;
    logic [3:0]        cap_be;
    logic [DATA_W-1:0] cap_wdata, cap_result;
    logic [2:0]        cap_f3;
    logic [1:0]        cap_a;
    logic [4:0]        cap_rd;

    logic              mem_op, bad, legal_op;
    logic [3:0]        be;
    logic [DATA_W-1:0] wdata, ld_data;

    load_store_align u_align (
        .funct3     (funct3),
        .addr_lo    (Result[1:0]),
        .mRead      (mRead),
        .mWrite     (mWrite),
        .sdata      (SrcB),
        .ld_funct3  (cap_f3),
        .ld_addr_lo (cap_a),
        .rdata      (dm_rdata),
        .be         (be),
        .wdata      (wdata),
        .bad        (bad),
        .ld_data    (ld_data)
    );

    assign mem_op   = ex_valid && (mRead || mWrite);
    assign legal_op = mem_op && !bad;

    // Gated by rst so a held mem op cannot raise stall while in reset.
    assign stall_o = rst && ((state == IDLE   && legal_op) ||
                             (state == ACCESS && !dm_ack));

    assign dm_req   = (state == ACCESS);
    assign dm_we    = cap_we;
    assign dm_addr  = cap_addr;
    assign dm_be    = cap_be;
    assign dm_wdata = cap_wdata;

    assign wb_valid    = wb_q.valid;
    assign wb_rgWrite  = wb_q.rgWrite;
    assign wb_m2Reg    = wb_q.m2Reg;
    assign wb_rd       = wb_q.rd;
    assign wb_ReadData = wb_q.ReadData;
    assign wb_Result   = wb_q.Result;
    assign misalign_o  = misalign_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            wb_q        <= '0;
            misalign_q  <= 1'b0;
            cap_we      <= 1'b0;
            cap_rgWrite <= 1'b0;
            cap_m2Reg   <= 1'b0;
            cap_addr    <= '0;
            cap_be      <= '0;
            cap_wdata   <= '0;
            cap_result  <= '0;
            cap_f3      <= '0;
            cap_a       <= '0;
            cap_rd      <= '0;
        end else begin
            wb_q.valid   <= 1'b0;
            wb_q.rgWrite <= 1'b0;
            misalign_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (legal_op) begin
                        state       <= ACCESS;
                        cap_we      <= mWrite;
                        cap_rgWrite <= rgWrite;
                        cap_m2Reg   <= m2Reg;
                        cap_addr    <= {Result[ADDR_W-1:2], 2'b00};
                        cap_be      <= be;
                        cap_wdata   <= wdata;
                        cap_result  <= Result;
                        cap_f3      <= funct3;
                        cap_a       <= Result[1:0];
                        cap_rd      <= rd;
                    end else if (ex_valid) begin
                        // Non-memory op or rejected access: one-cycle response.
                        wb_q.valid    <= 1'b1;
                        wb_q.rgWrite  <= rgWrite && !mem_op;
                        wb_q.m2Reg    <= m2Reg && !mem_op;
                        wb_q.rd       <= rd;
                        wb_q.ReadData <= '0;
                        wb_q.Result   <= Result;
                        misalign_q    <= mem_op;
                    end
                end
                ACCESS: begin
                    if (dm_ack) begin
                        state         <= IDLE;
                        wb_q.valid    <= 1'b1;
                        wb_q.rgWrite  <= cap_rgWrite;
                        wb_q.m2Reg    <= cap_m2Reg;
                        wb_q.rd       <= cap_rd;
                        wb_q.ReadData <= cap_we ? '0 : ld_data;
                        wb_q.Result   <= cap_result;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed cases plus random
// instruction stream checked against a transaction-level reference model.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ex_valid = 0, mRead = 0, mWrite = 0, m2Reg = 0, rgWrite = 0;
    logic [2:0]  funct3 = 0;
    logic [4:0]  rd = 0;
    logic [31:0] Result = 0, SrcB = 0;
    logic        stall_o, dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic [3:0]  dm_be;
    logic        dm_ack = 0;
    logic [31:0] dm_rdata = 0;
    logic        wb_valid, wb_rgWrite, wb_m2Reg, misalign_o;
    logic [4:0]  wb_rd;
    logic [31:0] wb_ReadData, wb_Result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_stage dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .mRead(mRead), .mWrite(mWrite),
        .m2Reg(m2Reg), .rgWrite(rgWrite), .funct3(funct3), .rd(rd),
        .Result(Result), .SrcB(SrcB), .stall_o(stall_o), .dm_req(dm_req),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata), .wb_valid(wb_valid),
        .wb_rgWrite(wb_rgWrite), .wb_m2Reg(wb_m2Reg), .wb_rd(wb_rd),
        .wb_ReadData(wb_ReadData), .wb_Result(wb_Result), .misalign_o(misalign_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---- reference model: access size in bytes, 0 for undefined sizes ----
    function automatic int acc_size(input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    return 1;
            2'd1:    return 2;
            2'd2:    return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit model_bad(input bit mr, input bit mw, input logic [2:0] f3,
                                     input int a);
        int sz = acc_size(f3);
        if (mr && mw) return 1;
        if (mr && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1;
        if (mw && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1;
        if (sz == 0) return 1;
        return (a % sz) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input int a);
        int sz = acc_size(f3);
        return 4'(((1 << sz) - 1) << a);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] s);
        case (acc_size(f3))
            1:       return (s & 32'hFF) * 32'h0101_0101;
            2:       return (s & 32'hFFFF) * 32'h0001_0001;
            default: return s;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input int a,
                                               input logic [31:0] w);
        int          sz   = acc_size(f3);
        logic [31:0] mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 1);
        logic [31:0] v    = (w >> (8 * a)) & mask;
        if (!f3[2] && sz < 4 && v[8*sz-1])
            v = v | ~mask;
        return v;
    endfunction

    // Present one instruction and follow it until its MEM/WB response is visible.
    task automatic do_instr(input bit v, input bit mr, input bit mw, input bit m2,
                            input bit rw, input logic [2:0] f3, input logic [4:0] rdi,
                            input logic [31:0] res, input logic [31:0] src,
                            input int dly, input logic [31:0] rdat);
        int a       = int'(res[1:0]);
        bit mem     = v && (mr || mw);
        bit bad     = mem && model_bad(mr, mw, f3, a);
        bit go      = mem && !bad;
        logic [31:0] exp_rd = 0;
        ex_valid = v; mRead = mr; mWrite = mw; m2Reg = m2; rgWrite = rw;
        funct3 = f3; rd = rdi; Result = res; SrcB = src; dm_ack = 0;
        #1;
        chk("idle_req", dm_req, 0);
        chk("idle_stall", stall_o, go);
        @(posedge clk); #1;
        if (go) begin
            for (int d = 0; d <= dly; d++) begin
                dm_ack   = (d == dly);
                dm_rdata = (d == dly) ? rdat : $urandom;
                #1;
                chk("acc_req", dm_req, 1);
                chk("acc_we", dm_we, mw);
                chk("acc_addr", dm_addr, res & 32'hFFFF_FFFC);
                chk("acc_be", dm_be, model_be(f3, a));
                if (mw) chk("acc_wdata", dm_wdata, model_wdata(f3, src));
                chk("acc_stall", stall_o, d != dly);
                chk("acc_wbv", wb_valid, 0);
                @(posedge clk); #1;
            end
            dm_ack = 0;
            if (mr) exp_rd = model_load(f3, a, rdat);
        end
        chk("wb_valid", wb_valid, v);
        chk("wb_rgWrite", wb_rgWrite, v && !bad && rw);
        chk("misalign", misalign_o, bad);
        if (v && !bad) begin
            chk("wb_rd", wb_rd, rdi);
            chk("wb_Result", wb_Result, res);
            chk("wb_m2Reg", wb_m2Reg, m2);
            if (!mw) chk("wb_ReadData", wb_ReadData, exp_rd);
        end
    endtask

    task automatic idle_cycle(input bit stray_ack);
        ex_valid = 0; mRead = 0; mWrite = 0; dm_ack = stray_ack;
        #1;
        chk("nop_req", dm_req, 0);
        chk("nop_stall", stall_o, 0);
        @(posedge clk); #1;
        dm_ack = 0;
        chk("nop_wbv", wb_valid, 0);
        chk("nop_rgw", wb_rgWrite, 0);
        chk("nop_mis", misalign_o, 0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", dm_req, 0);
        chk("rst_stall", stall_o, 0);
        chk("rst_wbv", wb_valid, 0);
        chk("rst_wbres", wb_Result, 0);
        rst = 1;
        @(posedge clk); #1;

        // SB to byte 3
        do_instr(1, 0, 1, 0, 0, 3'b000, 5'd0, 32'h0000_1003, 32'h0000_00AB, 0, 32'h0);
        // LB / LBU / LH at 0x2002
        do_instr(1, 1, 0, 1, 1, 3'b000, 5'd3, 32'h0000_2002, 32'h0, 0, 32'h1280_3456);
        chk("lb_const", wb_ReadData, 32'hFFFF_FF80);
        do_instr(1, 1, 0, 1, 1, 3'b100, 5'd3, 32'h0000_2002, 32'h0, 0, 32'h1280_3456);
        chk("lbu_const", wb_ReadData, 32'h0000_0080);
        do_instr(1, 1, 0, 1, 1, 3'b001, 5'd3, 32'h0000_2002, 32'h0, 0, 32'h1280_3456);
        chk("lh_const", wb_ReadData, 32'h0000_1280);
        // Misaligned LW
        do_instr(1, 1, 0, 1, 1, 3'b010, 5'd4, 32'h0000_3002, 32'h0, 0, 32'h0);
        // LW with ack delayed three cycles
        do_instr(1, 1, 0, 1, 1, 3'b010, 5'd5, 32'h0000_4000, 32'h0, 3, 32'hCAFE_F00D);
        chk("lw_const", wb_ReadData, 32'hCAFE_F00D);
        // Back-to-back ALU ops
        do_instr(1, 0, 0, 0, 1, 3'b000, 5'd7, 32'hDEAD_BEEF, 32'h0, 0, 32'h0);
        do_instr(1, 0, 0, 0, 1, 3'b000, 5'd8, 32'h0000_0001, 32'h0, 0, 32'h0);
        idle_cycle(1'b1);

        // Reset asserted in the second ACCESS cycle
        ex_valid = 1; mRead = 1; mWrite = 0; rgWrite = 1; funct3 = 3'b010;
        Result = 32'h0000_5000; dm_ack = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_req", dm_req, 1);
        rst = 0;
        #1;
        chk("arst_req", dm_req, 0);
        chk("arst_stall", stall_o, 0);
        chk("arst_wbv", wb_valid, 0);
        chk("arst_rd", wb_rd, 0);
        chk("arst_res", wb_Result, 0);
        chk("arst_data", wb_ReadData, 0);
        @(posedge clk); #1;
        ex_valid = 0;
        rst = 1;
        idle_cycle(1'b1);
        idle_cycle(1'b0);

        // Random instruction stream
        for (int n = 0; n < 400; n++) begin
            int          op  = $urandom_range(0, 9);
            logic [2:0]  f3  = 3'($urandom_range(0, 7));
            bit          mr  = (op >= 4 && op <= 6) || op == 9;
            bit          mw  = (op == 7 || op == 8 || op == 9);
            logic [31:0] res = $urandom;
            if (op == 3) idle_cycle($urandom_range(0, 1) == 1);
            else if (mw && !mr && $urandom_range(0, 3) != 0)
                do_instr(1, mr, mw, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                         3'($urandom_range(0, 2)), 5'($urandom), res, $urandom,
                         $urandom_range(0, 3), $urandom);
            else
                do_instr($urandom_range(0, 15) != 0, mr, mw, $urandom_range(0, 1) == 1,
                         $urandom_range(0, 1) == 1, f3, 5'($urandom), res, $urandom,
                         $urandom_range(0, 3), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks %0d", checks);
        $fatal(1);
    end

endmodule
